versat_burst_reader: RTL and testbench

//  Databus read master feeding one slave port of the IO merge stage (merge -> SimpleAXI -> AXI4).

---
 rtl/versat_burst_reader_if.sv | 32 +++
 rtl/versat_burst_reader.sv | 159 +++++++++++++++
 tb/tb_versat_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/versat_burst_reader_if.sv
// Databus read channel plus output stream of versat_burst_reader.
// master = the burst reader itself, slave = interconnect/consumer side.
interface versat_burst_reader_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  databus_valid;
  logic                  databus_ready;
  logic [ADDR_W-1:0]     databus_addr;
  logic [DATA_W-1:0]     databus_wdata;
  logic [DATA_W/8-1:0]   databus_wstrb;
  logic [7:0]            databus_len;
  logic                  databus_last;
  logic [DATA_W-1:0]     databus_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len,
    input  databus_ready, databus_last, databus_rdata,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb, databus_len,
    output databus_ready, databus_last, databus_rdata,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/versat_burst_reader.sv
// Burst read master: splits a linear read into INCR bursts, buffers beats in a FWFT FIFO.
// Define VERSAT_BURST_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module versat_burst_reader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 20,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   total_words,
  output logic               busy,
  output logic               done,
  versat_burst_reader_if.master bus
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BURST_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WAIT,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [BURST_W-1:0]  burst_q;
  logic [BURST_W-1:0]  burst_calc;
  logic [LEN_W-1:0]    lim;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    fifo_free;
  logic                out_valid_q;
  logic                push, pop, last_beat;

  assign push      = (state_q == S_BURST) && bus.databus_ready;
  assign last_beat = push && bus.databus_last;
  assign pop       = out_valid_q && bus.out_ready;
  assign fifo_free = CNT_W'(FIFO_DEPTH) - count_q;

  assign bus.databus_addr  = addr_q;
  assign bus.databus_len   = len_q;
  assign bus.databus_wdata = '0;
  assign bus.databus_wstrb = '0;
  assign bus.out_valid     = out_valid_q;
  // Gate the head so stale memory never shows while the FIFO is empty
  assign bus.out_data      = out_valid_q ? mem[rd_ptr_q] : '0;

`ifdef VERSAT_BURST_4K_SPLIT_EN
  logic [LEN_W-1:0] page_words;
`endif

  // Burst size for the next request
  always_comb begin
    lim = (remaining_q < LEN_W'(MAX_BURST)) ? remaining_q : LEN_W'(MAX_BURST);
`ifdef VERSAT_BURST_4K_SPLIT_EN
    page_words = LEN_W'((13'h1000 - {1'b0, addr_q[11:0]}) >> $clog2(BYTES));
    if (page_words < lim) lim = page_words;
`else
    lim = lim;
`endif
    burst_calc = BURST_W'(lim);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (total_words != '0)) state_d = S_CALC;
      S_CALC:  state_d = S_WAIT;
      S_WAIT:  if (fifo_free >= CNT_W'(burst_q)) state_d = S_BURST;
      S_BURST: if (last_beat)
                 state_d = (remaining_q == LEN_W'(burst_q)) ? S_DRAIN : S_CALC;
      S_DRAIN: if (count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register, registered outputs and transfer bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.databus_valid <= 1'b0;
      addr_q            <= '0;
      remaining_q       <= '0;
      burst_q           <= '0;
      len_q             <= '0;
      beat_q            <= '0;
    end else begin
      state_q           <= state_d;
      busy              <= (state_d != S_IDLE);
      done              <= ((state_q == S_IDLE) && start && (total_words == '0)) ||
                           ((state_q == S_DRAIN) && (state_d == S_IDLE));
      bus.databus_valid <= (state_d == S_BURST);
      if ((state_q == S_IDLE) && (state_d == S_CALC)) begin
        addr_q      <= base_addr & ~ADDR_W'(BYTES - 1);
        remaining_q <= total_words;
      end
      if (state_q == S_CALC) begin
        burst_q <= burst_calc;
        len_q   <= 8'(burst_calc - BURST_W'(1));
      end
      if (push) beat_q <= bus.databus_last ? 8'd0 : beat_q + 8'd1;
      if (last_beat) begin
        addr_q      <= addr_q + ADDR_W'(burst_q) * ADDR_W'(BYTES);
        remaining_q <= remaining_q - LEN_W'(burst_q);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.databus_rdata;
  end

  a_beats_match_len: assert property (@(posedge clk) disable iff (rst)
    last_beat |-> (beat_q == len_q));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (count_q != CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_versat_burst_reader.sv
// Directed bench for versat_burst_reader with a databus slave model and a stream consumer.
module tb_versat_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [19:0] total_words;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  bit pop_free = 0;
  int pop_budget = 0;

  logic [31:0] req_addr_q [$];
  logic [7:0]  req_len_q  [$];
  logic [31:0] rx_q       [$];

  versat_burst_reader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  versat_burst_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .total_words (total_words),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Databus slave: returns the byte address as data, one bubble at beat 2
  int          sl_left;
  int          sl_idx;
  logic [31:0] sl_addr;
  bit          sl_active;
  bit          sl_bubbled;
  always @(negedge clk) begin
    if (rst) begin
      sl_active = 0;
      bus.databus_ready = 1'b0;
      bus.databus_last  = 1'b0;
      bus.databus_rdata = '0;
    end else if (!sl_active) begin
      if (bus.databus_valid) begin
        req_addr_q.push_back(bus.databus_addr);
        req_len_q.push_back(bus.databus_len);
        sl_active  = 1;
        sl_addr    = bus.databus_addr;
        sl_left    = int'(bus.databus_len) + 1;
        sl_idx     = 0;
        sl_bubbled = 0;
        bus.databus_ready = 1'b1;
        bus.databus_rdata = sl_addr;
        bus.databus_last  = (sl_left == 1);
      end else begin
        bus.databus_ready = 1'b0;
        bus.databus_last  = 1'b0;
      end
    end else begin
      if (bus.databus_ready) begin
        sl_left--;
        sl_addr += 32'd4;
        sl_idx++;
      end
      if (sl_left == 0) begin
        sl_active = 0;
        bus.databus_ready = 1'b0;
        bus.databus_last  = 1'b0;
      end else if (sl_idx == 2 && !sl_bubbled) begin
        sl_bubbled = 1;
        bus.databus_ready = 1'b0;
        bus.databus_last  = 1'b0;
      end else begin
        bus.databus_ready = 1'b1;
        bus.databus_rdata = sl_addr;
        bus.databus_last  = (sl_left == 1);
      end
    end
  end

  // Consumer: free-running or a counted number of pops
  always @(negedge clk) begin
    if (rst) begin
      bus.out_ready = 1'b0;
    end else begin
      bus.out_ready = pop_free || (pop_budget > 0);
      if (bus.out_ready && bus.out_valid) begin
        rx_q.push_back(bus.out_data);
        if (!pop_free && pop_budget > 0) pop_budget--;
      end
    end
  end

  always @(negedge clk) if (!rst && done) done_cnt++;

  task automatic clear_logs();
    @(posedge clk);
    req_addr_q.delete();
    req_len_q.delete();
    rx_q.delete();
  endtask

  task automatic do_start(input logic [31:0] a, input logic [19:0] n);
    @(negedge clk);
    start = 1'b1; base_addr = a; total_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_req(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    check($sformatf("%s_req%0d_addr", tag, idx),
          (req_addr_q.size() > idx) ? 64'(req_addr_q[idx]) : 64'hFFFF_FFFF_FFFF, 64'(a));
    check($sformatf("%s_req%0d_len", tag, idx),
          (req_len_q.size() > idx) ? 64'(req_len_q[idx]) : 64'hFFFF_FFFF_FFFF, 64'(l));
  endtask

  task automatic check_rx(input string tag, input logic [31:0] a, input int n);
    check({tag, "_rx_count"}, 64'(rx_q.size()), 64'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++)
      check($sformatf("%s_rx%0d", tag, k), 64'(rx_q[k]), 64'(a + 32'(4 * k)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    bit seen;
    rst = 1'b1; start = 1'b0; base_addr = '0; total_words = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",      64'(busy),              64'd0);
    check("rst_done",      64'(done),              64'd0);
    check("rst_valid",     64'(bus.databus_valid), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid),     64'd0);
    check("rst_len",       64'(bus.databus_len),   64'd0);
    check("rst_addr",      64'(bus.databus_addr),  64'd0);
    check("rst_wstrb",     64'(bus.databus_wstrb), 64'd0);
    @(negedge clk) rst = 1'b0;

    // 1: single short burst
    @(posedge clk) pop_free = 1;
    clear_logs();
    do_start(32'h1000, 20'd5);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 300);
    @(negedge clk) check("t1_done_pulse", 64'(done), 64'd0);
    @(posedge clk);
    check("t1_nreq", 64'(req_addr_q.size()), 64'd1);
    check_req("t1", 0, 32'h1000, 8'd4);
    check_rx("t1", 32'h1000, 5);

    // 2: split into MAX_BURST pieces
    clear_logs();
    do_start(32'h1000, 20'd40);
    wait_done("t2", 600);
    @(posedge clk);
    check("t2_nreq", 64'(req_addr_q.size()), 64'd3);
    check_req("t2", 0, 32'h1000, 8'd15);
    check_req("t2", 1, 32'h1040, 8'd15);
    check_req("t2", 2, 32'h1080, 8'd7);
    check_rx("t2", 32'h1000, 40);

    // 3: backpressure, no burst without room
    @(posedge clk) pop_free = 0;
    clear_logs();
    do_start(32'h2000, 20'd64);
    repeat (150) @(negedge clk);
    check("t3_full_out_valid", 64'(bus.out_valid),     64'd1);
    check("t3_full_dbvalid",   64'(bus.databus_valid), 64'd0);
    @(posedge clk);
    check("t3_full_nreq", 64'(req_addr_q.size()), 64'd2);
    pop_budget = 15;
    repeat (40) @(negedge clk);
    @(posedge clk);
    check("t3_pop15_nreq", 64'(req_addr_q.size()), 64'd2);
    check("t3_pop15_rx",   64'(rx_q.size()),       64'd15);
    pop_budget = 1;
    repeat (40) @(negedge clk);
    @(posedge clk);
    check("t3_pop16_nreq", 64'(req_addr_q.size()), 64'd3);
    pop_free = 1;
    wait_done("t3", 800);
    @(posedge clk);
    check("t3_nreq", 64'(req_addr_q.size()), 64'd4);
    check_req("t3", 2, 32'h2080, 8'd15);
    check_req("t3", 3, 32'h20C0, 8'd15);
    check_rx("t3", 32'h2000, 64);

    // 4: burst near a 4 KB boundary
    clear_logs();
    do_start(32'h0FF8, 20'd8);
    wait_done("t4", 300);
    @(posedge clk);
`ifdef VERSAT_BURST_4K_SPLIT_EN
    check("t4_nreq", 64'(req_addr_q.size()), 64'd2);
    check_req("t4", 0, 32'h0FF8, 8'd1);
    check_req("t4", 1, 32'h1000, 8'd5);
`else
    check("t4_nreq", 64'(req_addr_q.size()), 64'd1);
    check_req("t4", 0, 32'h0FF8, 8'd7);
`endif
    check_rx("t4", 32'h0FF8, 8);

    // 5: zero-length start, then start while busy
    clear_logs();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h5000; total_words = 20'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_zero_done", 64'(done), 64'd1);
    check("t5_zero_busy", 64'(busy), 64'd0);
    @(negedge clk) check("t5_zero_done_clr", 64'(done), 64'd0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    check("t5_zero_nreq", 64'(req_addr_q.size()), 64'd0);
    check("t5_zero_dcnt", 64'(done_cnt - d0), 64'd1);
    pop_free = 0;
    do_start(32'h6000, 20'd5);
    repeat (20) @(negedge clk);
    check("t5_busy_held", 64'(busy), 64'd1);
    do_start(32'h7000, 20'd3);
    repeat (5) @(negedge clk);
    @(posedge clk) pop_free = 1;
    wait_done("t5", 300);
    repeat (20) @(negedge clk);
    @(posedge clk);
    check("t5_nreq", 64'(req_addr_q.size()), 64'd1);
    check_req("t5", 0, 32'h6000, 8'd4);
    check_rx("t5", 32'h6000, 5);
    check("t5_dcnt", 64'(done_cnt - d0), 64'd2);

    // 6: reset in the middle of a burst
    pop_free = 0;
    clear_logs();
    do_start(32'h3000, 20'd16);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.databus_valid) seen = 1;
    end
    check("t6_valid_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid",     64'(bus.databus_valid), 64'd0);
    check("t6_rst_busy",      64'(busy),              64'd0);
    check("t6_rst_done",      64'(done),              64'd0);
    check("t6_rst_out_valid", 64'(bus.out_valid),     64'd0);
    check("t6_rst_out_data",  64'(bus.out_data),      64'd0);
    check("t6_rst_len",       64'(bus.databus_len),   64'd0);
    @(negedge clk) rst = 1'b0;
    clear_logs();
    pop_free = 1;
    do_start(32'h4000, 20'd3);
    wait_done("t6", 300);
    @(posedge clk);
    check("t6_nreq", 64'(req_addr_q.size()), 64'd1);
    check_req("t6", 0, 32'h4000, 8'd2);
    check_rx("t6", 32'h4000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
